// File: rtl/writeback_queue.sv
// rtl/writeback_queue.sv - two-producer write-back FIFO draining onto the register-file write port
//
// Build option: define WBQ_FORWARD_EN to build the read-forwarding lookup.
// Without it, the fwd_* outputs are tied to zero.
//
// Ports:
//   clk, rst                      clock and asynchronous active-high reset
//   mem_valid/mem_reg/mem_data    memory-load write request; mem_ready accepts it
//   alu_valid/alu_reg/alu_data    ALU write request; alu_ready accepts it
//   WriteReg, WriteData           registered register-file write port (idle value 0/0)
//   fwd_reg1/2 -> fwd_hit1/2      combinational lookup of pending writes
//   fwd_data1/2                   data returned by that lookup
//   count                         number of occupied FIFO entries
module writeback_queue #(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       mem_valid,
    input  logic [2:0]                 mem_reg,
    input  logic [7:0]                 mem_data,
    output logic                       mem_ready,
    input  logic                       alu_valid,
    input  logic [2:0]                 alu_reg,
    input  logic [7:0]                 alu_data,
    output logic                       alu_ready,
    output logic [2:0]                 WriteReg,
    output logic [7:0]                 WriteData,
    input  logic [2:0]                 fwd_reg1,
    input  logic [2:0]                 fwd_reg2,
    output logic                       fwd_hit1,
    output logic                       fwd_hit2,
    output logic [7:0]                 fwd_data1,
    output logic [7:0]                 fwd_data2,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [2:0]    ent_reg_q  [DEPTH];
    logic [2:0]    ent_reg_d  [DEPTH];
    logic [7:0]    ent_data_q [DEPTH];
    logic [7:0]    ent_data_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [2:0]    write_reg_q, write_reg_d;
    logic [7:0]    write_data_q, write_data_d;

    logic [CW-1:0] free;
    logic          mem_push;
    logic          alu_push;
    logic          pop;
    logic [PW-1:0] alu_slot;

    always_comb begin
        // Free slots give no credit for a pop on the same edge, so the
        // queue can never be over-filled even when it drains concurrently.
        free      = CW'(DEPTH) - count_q;
        mem_ready = (free >= CW'(1));
        alu_ready = (free >= CW'(2)) || ((free >= CW'(1)) && !mem_valid);

        // Writes to R0 are acknowledged but dropped: R0 is hard-wired zero.
        mem_push = mem_valid && mem_ready && (mem_reg != 3'd0);
        alu_push = alu_valid && alu_ready && (alu_reg != 3'd0);
        pop      = (count_q != '0);

        ent_reg_d  = ent_reg_q;
        ent_data_d = ent_data_q;
        // The memory write is the older one, so it takes the first slot.
        alu_slot   = wr_ptr_q + PW'(mem_push);
        if (mem_push) begin
            ent_reg_d[wr_ptr_q]  = mem_reg;
            ent_data_d[wr_ptr_q] = mem_data;
        end
        if (alu_push) begin
            ent_reg_d[alu_slot]  = alu_reg;
            ent_data_d[alu_slot] = alu_data;
        end

        wr_ptr_d = wr_ptr_q + PW'(mem_push) + PW'(alu_push);
        rd_ptr_d = rd_ptr_q + PW'(pop);
        count_d  = count_q + CW'(mem_push) + CW'(alu_push) - CW'(pop);

        write_reg_d  = pop ? ent_reg_q[rd_ptr_q]  : 3'd0;
        write_data_d = pop ? ent_data_q[rd_ptr_q] : 8'd0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_reg_q[i]  <= '0;
                ent_data_q[i] <= '0;
            end
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            write_reg_q  <= '0;
            write_data_q <= '0;
        end else begin
            ent_reg_q    <= ent_reg_d;
            ent_data_q   <= ent_data_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            write_reg_q  <= write_reg_d;
            write_data_q <= write_data_d;
        end
    end

    assign WriteReg  = write_reg_q;
    assign WriteData = write_data_q;
    assign count     = count_q;

`ifdef WBQ_FORWARD_EN
    logic [PW-1:0] idx;

    // Scan oldest to youngest so later matches overwrite earlier ones; the
    // output stage is older than every FIFO entry and is checked first.
    always_comb begin
        fwd_hit1  = 1'b0;
        fwd_data1 = 8'd0;
        fwd_hit2  = 1'b0;
        fwd_data2 = 8'd0;
        idx       = '0;
        if (fwd_reg1 != 3'd0 && write_reg_q == fwd_reg1) begin
            fwd_hit1  = 1'b1;
            fwd_data1 = write_data_q;
        end
        if (fwd_reg2 != 3'd0 && write_reg_q == fwd_reg2) begin
            fwd_hit2  = 1'b1;
            fwd_data2 = write_data_q;
        end
        for (int k = 0; k < DEPTH; k++) begin
            idx = rd_ptr_q + PW'(k);
            if (CW'(k) < count_q) begin
                if (fwd_reg1 != 3'd0 && ent_reg_q[idx] == fwd_reg1) begin
                    fwd_hit1  = 1'b1;
                    fwd_data1 = ent_data_q[idx];
                end
                if (fwd_reg2 != 3'd0 && ent_reg_q[idx] == fwd_reg2) begin
                    fwd_hit2  = 1'b1;
                    fwd_data2 = ent_data_q[idx];
                end
            end
        end
    end
`else
    logic unused_fwd;
    assign unused_fwd = ^{fwd_reg1, fwd_reg2};
    assign fwd_hit1   = 1'b0;
    assign fwd_hit2   = 1'b0;
    assign fwd_data1  = 8'd0;
    assign fwd_data2  = 8'd0;
`endif

endmodule
